fetch_unit: RTL and testbench

//  Instruction fetch stage upstream of the decoder/control unit. Owns the PC register,

---
 rtl/fetch_unit_if.sv | 42 ++++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction-memory and decode/retire signal bundle of the
//               fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_rvalid_i;
   logic [31:0]     imem_rdata_i;
   logic [31:0]     instr_o;
   logic [XLEN-1:0] pc_o;
   logic            instr_valid_o;
   logic            retire_i;
   logic            jal_i;
   logic            jalr_i;
   logic            branch_i;
   logic            branch_taken_i;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] rs1_i;
   logic            misalign_o;
   logic [XLEN-1:0] instret_o;

   modport master (
      output imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o,
             misalign_o, instret_o,
      input  imem_rvalid_i, imem_rdata_i, retire_i, jal_i, jalr_i,
             branch_i, branch_taken_i, imm_i, rs1_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o,
             misalign_o, instret_o,
      output imem_rvalid_i, imem_rdata_i, retire_i, jal_i, jalr_i,
             branch_i, branch_taken_i, imm_i, rs1_i
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC owner and instruction fetch stage; holds each fetched word
//               for decode until retire, then redirects via jal/jalr/branch.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
)(
   input  wire          clk_i,
   input  wire          rst_ni,
   fetch_unit_if.master bus
);

   localparam logic [31:0]     c_NOP       = 32'h0000_0013;
   localparam logic [XLEN-1:0] c_INC       = XLEN'(4);
   localparam logic [XLEN-1:0] c_JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

   typedef enum logic [2:0] {
      S_RST   = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_ISSUE = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [31:0]     r_instr;
   logic [XLEN-1:0] r_instret;
   logic [XLEN-1:0] w_next_pc;
   logic            w_misalign;
   logic            w_retire;
   logic            w_capture;

   // jalr has top priority; its LSB is cleared before the alignment check
   always_comb begin
      w_next_pc = r_pc + c_INC;
      if (bus.jalr_i) begin
         w_next_pc = (bus.rs1_i + bus.imm_i) & c_JALR_MASK;
      end else if (bus.jal_i || (bus.branch_i && bus.branch_taken_i)) begin
         w_next_pc = r_pc + bus.imm_i;
      end
   end

   assign w_misalign = |w_next_pc[1:0];
   assign w_retire   = (r_state == S_ISSUE) && bus.retire_i;
   assign w_capture  = (r_state == S_WAIT) && bus.imem_rvalid_i;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RST:   w_state_nxt = S_FETCH;
         S_FETCH: w_state_nxt = S_WAIT;
         S_WAIT:  if (bus.imem_rvalid_i) w_state_nxt = S_ISSUE;
         S_ISSUE: if (bus.retire_i) w_state_nxt = w_misalign ? S_FAULT : S_FETCH;
         S_FAULT: w_state_nxt = S_FAULT;
         default: w_state_nxt = S_RST;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_RST;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pc      <= RESET_PC;
         r_instr   <= c_NOP;
         r_instret <= '0;
      end else begin
         if (w_capture) begin
            r_instr <= bus.imem_rdata_i;
         end
         // the faulting jump still retires, so pc_o shows the bad target
         if (w_retire) begin
            r_pc      <= w_next_pc;
            r_instret <= r_instret + XLEN'(1);
         end
      end
   end

   assign bus.imem_req_o    = (r_state == S_FETCH);
   assign bus.imem_addr_o   = r_pc;
   assign bus.instr_o       = r_instr;
   assign bus.pc_o          = r_pc;
   assign bus.instr_valid_o = (r_state == S_ISSUE);
   assign bus.misalign_o    = (r_state == S_FAULT);
   assign bus.instret_o     = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed scoreboard bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
   localparam int          XLEN = 32;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_instr_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_instret;

   always #5 clk = ~clk;

   fetch_unit_if #(.XLEN(XLEN)) bus();

   fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [31:0] pop_addr();
      if (exp_addr_q.size() == 0) return 32'hxxxx_xxxx;
      return exp_addr_q.pop_front();
   endfunction

   function automatic logic [31:0] pop_instr();
      if (exp_instr_q.size() == 0) return 32'hxxxx_xxxx;
      return exp_instr_q.pop_front();
   endfunction

   function automatic logic [31:0] model_next(input logic [31:0] pc, input bit jal, input bit jalr,
                                              input bit br, input bit tk,
                                              input logic [31:0] imm, input logic [31:0] rs1);
      if (jalr) return (rs1 + imm) & 32'hFFFF_FFFE;
      if (jal || (br && tk)) return pc + imm;
      return pc + 32'd4;
   endfunction

   task automatic apply_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check({tag, "_req"},      32'(bus.imem_req_o),    32'd0);
      check({tag, "_addr"},     bus.imem_addr_o,        32'h0);
      check({tag, "_pc"},       bus.pc_o,               32'h0);
      check({tag, "_instr"},    bus.instr_o,            NOP);
      check({tag, "_valid"},    32'(bus.instr_valid_o), 32'd0);
      check({tag, "_misalign"}, 32'(bus.misalign_o),    32'd0);
      check({tag, "_instret"},  bus.instret_o,          32'd0);
      m_pc      = 32'h0;
      m_instret = 32'h0;
      exp_addr_q.delete();
      exp_instr_q.delete();
      exp_addr_q.push_back(32'h0);
      tick();
      tick();
   endtask

   // a stray rvalid may be driven across the RST cycle; it must not be captured
   task automatic release_reset(input string tag, input bit late_rvalid);
      if (late_rvalid) begin
         bus.imem_rvalid_i = 1'b1;
         bus.imem_rdata_i  = 32'hBAD0_BAD0;
      end
      rst_n = 1'b1;
      tick();
      bus.imem_rvalid_i = 1'b0;
      check({tag, "_req_cycle1"}, 32'(bus.imem_req_o), 32'd1);
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (bus.imem_req_o !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check({tag, "_req"}, 32'(bus.imem_req_o), 32'd1);
   endtask

   task automatic fetch(input string tag, input logic [31:0] word, input int lat, input bit junk_retire);
      wait_req(tag);
      check({tag, "_addr"}, bus.imem_addr_o, pop_addr());
      tick();
      check({tag, "_req_pulse"}, 32'(bus.imem_req_o), 32'd0);
      for (int i = 1; i < lat; i++) begin
         bus.retire_i = junk_retire;
         tick();
      end
      bus.retire_i      = 1'b0;
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = word;
      exp_instr_q.push_back(word);
      tick();
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = 32'hDEAD_BEEF;
      check({tag, "_valid"}, 32'(bus.instr_valid_o), 32'd1);
      check({tag, "_instr"}, bus.instr_o, pop_instr());
      check({tag, "_pc"},    bus.pc_o,    m_pc);
   endtask

   task automatic retire(input string tag, input bit jal, input bit jalr, input bit br, input bit tk,
                         input logic [31:0] imm, input logic [31:0] rs1);
      logic [31:0] nxt;
      nxt = model_next(m_pc, jal, jalr, br, tk, imm, rs1);
      bus.jal_i = jal; bus.jalr_i = jalr; bus.branch_i = br; bus.branch_taken_i = tk;
      bus.imm_i = imm; bus.rs1_i = rs1;
      bus.retire_i = 1'b1;
      tick();
      bus.retire_i = 1'b0; bus.jal_i = 1'b0; bus.jalr_i = 1'b0;
      bus.branch_i = 1'b0; bus.branch_taken_i = 1'b0;
      bus.imm_i = '0; bus.rs1_i = '0;
      m_pc = nxt;
      m_instret = m_instret + 32'd1;
      check({tag, "_instret"}, bus.instret_o, m_instret);
      if (nxt[1:0] == 2'b00) exp_addr_q.push_back(nxt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int nreq;
      rst_n = 1'b1;
      bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
      bus.retire_i = 1'b0; bus.jal_i = 1'b0; bus.jalr_i = 1'b0;
      bus.branch_i = 1'b0; bus.branch_taken_i = 1'b0;
      bus.imm_i = '0; bus.rs1_i = '0;
      #2;

      // basic fetch / retire
      apply_reset("rst0");
      release_reset("rel0", 1'b0);
      fetch("t1", NOP, 1, 1'b0);
      retire("t1_seq", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

      // slow memory with stray retire in WAIT, then a decode stall
      fetch("t2", 32'h0050_0093, 3, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_instr", bus.instr_o, 32'h0050_0093);
         check("stall_pc",    bus.pc_o,    32'h4);
         check("stall_req",   32'(bus.imem_req_o),    32'd0);
         check("stall_valid", 32'(bus.instr_valid_o), 32'd1);
      end
      retire("t2_jal4", 1'b1, 1'b0, 1'b0, 1'b0, 32'h4, 32'h0);

      // jal / jalr
      fetch("t3a", 32'h1000_006F, 1, 1'b0);
      retire("t3_jal", 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
      fetch("t3b", 32'h0040_8067, 2, 1'b0);
      retire("t3_jalr", 1'b0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h1001);
      fetch("t3c", 32'h0000_0067, 1, 1'b0);
      retire("t3_to20", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h20);

      // branches and jalr-over-jal priority
      fetch("t4a", 32'h0400_0063, 1, 1'b0);
      retire("t4_nt", 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
      fetch("t4b", 32'hFFDF_F06F, 1, 1'b0);
      retire("t4_back", 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0);
      fetch("t4c", 32'hFE00_0CE3, 1, 1'b0);
      retire("t4_tk", 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0);
      fetch("t4d", 32'h00C0_8067, 1, 1'b0);
      retire("t4_prio", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_000C, 32'hFFFF_FFF0);

      // PC wrap
      fetch("t6a", 32'h0000_0013, 1, 1'b0);
      retire("t6_wrap", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      fetch("t6b", 32'h0020_006F, 1, 1'b0);

      // misaligned target
      retire("t5_jal2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h2, 32'h0);
      check("t5_misalign", 32'(bus.misalign_o),    32'd1);
      check("t5_pc",       bus.pc_o,               32'h2);
      check("t5_valid",    32'(bus.instr_valid_o), 32'd0);
      nreq = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.imem_req_o !== 1'b0) nreq++;
      end
      check("t5_noreq", 32'(nreq), 32'd0);
      check("t5_sticky", 32'(bus.misalign_o), 32'd1);
      apply_reset("rst5");
      release_reset("rel5", 1'b0);

      // reset mid-WAIT, stray rvalid across RST
      wait_req("t6c");
      check("t6c_addr", bus.imem_addr_o, pop_addr());
      tick();
      check("t6c_wait", 32'(bus.imem_req_o), 32'd0);
      apply_reset("rst6");
      release_reset("rel6", 1'b1);
      fetch("t6d", 32'h0010_0093, 2, 1'b0);
      retire("t6d_seq", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      wait_req("t6e");
      check("t6e_addr", bus.imem_addr_o, pop_addr());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
